iex_adder_arbiter: RTL

//  Shares one u_alu_adder between two IEX requesters: req0 = ALU ops, req1 = address/branch-target calc.

---
 rtl/iex_adder_arbiter_pkg.sv | 27 ++
 rtl/iex_adder_arbiter_if.sv | 46 ++++
 rtl/iex_adder_arbiter_alu_adder.sv | 18 +
 rtl/iex_adder_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/iex_adder_arbiter_pkg.sv
// Shared widths, requester IDs and the response-register state type for the adder arbiter.
// ADDER_ARB_OVF_EN (optional) adds the signed-overflow flag on the response port.
`ifndef IEX_ADDER_ARB_DEFINES
`define IEX_ADDER_ARB_DEFINES
`define DATA_WIDTH 32
`define ARB_ID_ALU 1'b0
`define ARB_ID_AGU 1'b1
`endif

package iex_adder_arbiter_pkg;

  localparam int DATA_W_C = `DATA_WIDTH;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  // Overflow from sign bits only; sub compares against the un-inverted B.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                    input logic r_msb, input logic sub);
    logic same_sign;
    same_sign = sub ? (a_msb != b_msb) : (a_msb == b_msb);
    return same_sign & (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/iex_adder_arbiter_if.sv
// Requester and response handshake bundle for iex_adder_arbiter.
// rsp_ovf exists only when ADDER_ARB_OVF_EN is defined.
interface iex_adder_arbiter_if #(
  parameter int DATA_W = `DATA_WIDTH
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_sub;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;
`ifdef ADDER_ARB_OVF_EN
  logic              rsp_ovf;
`endif

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id
`ifdef ADDER_ARB_OVF_EN
    , output rsp_ovf
`endif
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id
`ifdef ADDER_ARB_OVF_EN
    , input rsp_ovf
`endif
  );

endinterface

// File: rtl/iex_adder_arbiter_alu_adder.sv
// Shared combinational adder: subtraction is A + ~B with carry-in 1, carry-out dropped.
module iex_adder_arbiter_alu_adder #(
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] w_b_op;
  logic [DATA_W-1:0] w_cin;

  assign w_b_op = i_b ^ {DATA_W{i_sub}};
  assign w_cin  = {{(DATA_W-1){1'b0}}, i_sub};
  assign o_sum  = i_a + w_b_op + w_cin;

endmodule

// File: rtl/iex_adder_arbiter.sv
// Round-robin share of one adder between ALU (req0) and AGU (req1), registered tagged response.
// Define ADDER_ARB_OVF_EN to register a signed-overflow flag alongside rsp_data.
//
// state    | meaning
// ST_EMPTY | response register holds no result (rsp_valid=0)
// ST_FULL  | response register holds a result awaiting rsp_ready
module iex_adder_arbiter
  import iex_adder_arbiter_pkg::*;
#(
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  iex_adder_arbiter_if.slave io_arb
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_last_grant;
  logic [DATA_W-1:0] r_data;
  logic              r_id;

  logic              w_can_accept;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_accept;
  logic              w_sel_id;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic              w_op_sub;
  logic [DATA_W-1:0] w_sum;

  // On a tie the requester that did not win last time gets the adder.
  assign w_grant1 = io_arb.req1_valid &
                    (!io_arb.req0_valid || (r_last_grant == `ARB_ID_ALU));
  assign w_grant0 = io_arb.req0_valid & !w_grant1;

  assign w_can_accept = (r_state == ST_EMPTY) | io_arb.rsp_ready;
  assign w_accept     = w_can_accept & (w_grant0 | w_grant1);
  assign w_sel_id     = w_grant1 ? `ARB_ID_AGU : `ARB_ID_ALU;

  assign w_op_a   = w_grant1 ? io_arb.req1_a   : io_arb.req0_a;
  assign w_op_b   = w_grant1 ? io_arb.req1_b   : io_arb.req0_b;
  assign w_op_sub = w_grant1 ? io_arb.req1_sub : io_arb.req0_sub;

  iex_adder_arbiter_alu_adder #(
    .DATA_W (DATA_W)
  ) u_alu_adder (
    .i_a   (w_op_a),
    .i_b   (w_op_b),
    .i_sub (w_op_sub),
    .o_sum (w_sum)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_accept)              w_state_nxt = ST_FULL;
        else if (io_arb.rsp_ready) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_last_grant <= `ARB_ID_AGU;
      r_data       <= '0;
      r_id         <= `ARB_ID_ALU;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_last_grant <= w_sel_id;
        r_data       <= w_sum;
        r_id         <= w_sel_id;
      end
    end
  end

`ifdef ADDER_ARB_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= ovf_calc(w_op_a[DATA_W-1], w_op_b[DATA_W-1], w_sum[DATA_W-1], w_op_sub);
    end
  end

  assign io_arb.rsp_ovf = r_ovf;
`endif

  assign io_arb.req0_ready = w_can_accept & w_grant0;
  assign io_arb.req1_ready = w_can_accept & w_grant1;
  assign io_arb.rsp_valid  = (r_state == ST_FULL);
  assign io_arb.rsp_data   = r_data;
  assign io_arb.rsp_id     = r_id;

endmodule
